// File: rtl/operand_entry_if.sv
// Key-stream and display bus between the key scanner, operand_entry and the display mux.
interface operand_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] hex0char_A;
  logic [3:0] hex1char_A;
  logic [3:0] hex2char_A;
  logic [3:0] bcdneg_A;
  logic [3:0] hex0char_B;
  logic [3:0] hex1char_B;
  logic [3:0] hex2char_B;
  logic [3:0] bcdneg_B;
  logic [1:0] display_select;
  logic       operands_valid;
  logic [1:0] entry_state;

  modport master (
    output key_valid, key_code,
    input  hex0char_A, hex1char_A, hex2char_A, bcdneg_A,
    input  hex0char_B, hex1char_B, hex2char_B, bcdneg_B,
    input  display_select, operands_valid, entry_state
  );

  modport slave (
    input  key_valid, key_code,
    output hex0char_A, hex1char_A, hex2char_A, bcdneg_A,
    output hex0char_B, hex1char_B, hex2char_B, bcdneg_B,
    output display_select, operands_valid, entry_state
  );
endinterface

// File: rtl/operand_entry.sv
// Keypad operand entry: builds two signed 3-digit BCD operands and flags a complete pair.
// Optional inactivity auto-clear is built when ENTRY_TIMEOUT_EN is defined.
module operand_entry #(
  parameter logic [3:0]  NEG_CODE       = 4'hA,
  parameter logic [3:0]  BLANK_CODE     = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_entry_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_READY   = 2'b10,
    ST_ERROR   = 2'b11
  } state_e;

  localparam logic [3:0] KEY_SIGN  = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;
  localparam logic [3:0] KEY_DIG_MAX = 4'd9;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("operand_entry: TIMEOUT_CYCLES must be at least 2");
  end

  state_e          r_state, w_state_nxt;
  logic [2:0][3:0] r_a, w_a_nxt;
  logic [2:0][3:0] r_b, w_b_nxt;
  logic [3:0]      r_sign_a, w_sign_a_nxt;
  logic [3:0]      r_sign_b, w_sign_b_nxt;
  logic            r_valid, w_valid_nxt;
  logic [1:0]      r_disp, w_disp_nxt;
  logic            w_timeout;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo;
  logic             w_entering;

  assign w_entering = (r_state == ST_ENTER_A) || (r_state == ST_ENTER_B);
  // A simultaneous key takes priority over the timeout.
  assign w_timeout  = w_entering && !bus.key_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (!w_entering || bus.key_valid || w_timeout || (w_state_nxt != r_state)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ENTER_A;
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= BLANK_CODE;
      r_sign_b <= BLANK_CODE;
      r_valid  <= 1'b0;
      r_disp   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_sign_a <= w_sign_a_nxt;
      r_sign_b <= w_sign_b_nxt;
      r_valid  <= w_valid_nxt;
      r_disp   <= w_disp_nxt;
    end
  end

  // Key decode, next state and next operand values.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_sign_a_nxt = r_sign_a;
    w_sign_b_nxt = r_sign_b;
    w_valid_nxt  = 1'b0;
    w_disp_nxt   = 2'b00;

    if (bus.key_valid) begin
      if (bus.key_code == KEY_CLEAR) begin
        w_state_nxt  = ST_ENTER_A;
        w_a_nxt      = '0;
        w_b_nxt      = '0;
        w_sign_a_nxt = BLANK_CODE;
        w_sign_b_nxt = BLANK_CODE;
      end else begin
        case (r_state)
          ST_ENTER_A: begin
            if (bus.key_code <= KEY_DIG_MAX) begin
              // A non-zero hundreds digit means the operand is full.
              if (r_a[2] == 4'd0) w_a_nxt = {r_a[1], r_a[0], bus.key_code};
            end else if (bus.key_code == KEY_SIGN) begin
              w_sign_a_nxt = (r_sign_a == NEG_CODE) ? BLANK_CODE : NEG_CODE;
            end else if (bus.key_code == KEY_ENTER) begin
              w_state_nxt = ST_ENTER_B;
            end else begin
              w_state_nxt = ST_ERROR;
            end
          end
          ST_ENTER_B: begin
            if (bus.key_code <= KEY_DIG_MAX) begin
              if (r_b[2] == 4'd0) w_b_nxt = {r_b[1], r_b[0], bus.key_code};
            end else if (bus.key_code == KEY_SIGN) begin
              w_sign_b_nxt = (r_sign_b == NEG_CODE) ? BLANK_CODE : NEG_CODE;
            end else if (bus.key_code == KEY_ENTER) begin
              w_state_nxt = ST_READY;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_ERROR;
            end
          end
          default: ;
        endcase
      end
    end else if (w_timeout) begin
      w_state_nxt  = ST_ENTER_A;
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_sign_a_nxt = BLANK_CODE;
      w_sign_b_nxt = BLANK_CODE;
    end

    // Display select is registered alongside the state so both change together.
    case (w_state_nxt)
      ST_ENTER_B: w_disp_nxt = 2'b01;
      ST_ERROR:   w_disp_nxt = 2'b10;
      default:    w_disp_nxt = 2'b00;
    endcase
  end

  assign bus.hex0char_A     = r_a[0];
  assign bus.hex1char_A     = r_a[1];
  assign bus.hex2char_A     = r_a[2];
  assign bus.bcdneg_A       = r_sign_a;
  assign bus.hex0char_B     = r_b[0];
  assign bus.hex1char_B     = r_b[1];
  assign bus.hex2char_B     = r_b[2];
  assign bus.bcdneg_B       = r_sign_b;
  assign bus.display_select = r_disp;
  assign bus.operands_valid = r_valid;
  assign bus.entry_state    = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry; timeout scenario is included when ENTRY_TIMEOUT_EN is defined.
module tb_operand_entry;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  operand_entry_if bus ();

  operand_entry #(
    .NEG_CODE      (4'hA),
    .BLANK_CODE    (4'hF),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [11:0] a_val;
  logic [11:0] b_val;
  assign a_val = {bus.hex2char_A, bus.hex1char_A, bus.hex0char_A};
  assign b_val = {bus.hex2char_B, bus.hex1char_B, bus.hex0char_B};

  // One strobe; returns on the falling edge after the key has been sampled.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_val, b_val} !== 24'h000000) begin
      n_err++; $display("FAIL reset_digits: got %h want %h", {a_val, b_val}, 24'h000000);
    end
    n_cmp++;
    if ({bus.bcdneg_A, bus.bcdneg_B} !== 8'hFF) begin
      n_err++; $display("FAIL reset_signs: got %h want %h", {bus.bcdneg_A, bus.bcdneg_B}, 8'hFF);
    end
    n_cmp++;
    if ({bus.display_select, bus.operands_valid, bus.entry_state} !== 5'b00_0_00) begin
      n_err++; $display("FAIL reset_ctrl: got %b want %b",
                        {bus.display_select, bus.operands_valid, bus.entry_state}, 5'b00_0_00);
    end
  endtask

  task automatic test_entry();
    press(4'd1); press(4'd2); press(4'd3);
    n_cmp++;
    if (a_val !== 12'h123) begin n_err++; $display("FAIL entry_a: got %h want %h", a_val, 12'h123); end
    n_cmp++;
    if (bus.bcdneg_A !== 4'hF) begin n_err++; $display("FAIL entry_sign: got %h want %h", bus.bcdneg_A, 4'hF); end
    n_cmp++;
    if (bus.display_select !== 2'b00) begin
      n_err++; $display("FAIL entry_disp: got %b want %b", bus.display_select, 2'b00);
    end
  endtask

  task automatic test_overflow();
    press(4'd11);
    press(4'd4); press(4'd5); press(4'd6); press(4'd7);
    n_cmp++;
    if (a_val !== 12'h456) begin n_err++; $display("FAIL overflow_a: got %h want %h", a_val, 12'h456); end
    n_cmp++;
    if (bus.entry_state !== 2'b00) begin
      n_err++; $display("FAIL overflow_state: got %b want %b", bus.entry_state, 2'b00);
    end
  endtask

  task automatic test_pair();
    press(4'd11);
    press(4'd9); press(4'd10); press(4'd12);
    n_cmp++;
    if ({bus.entry_state, bus.display_select} !== 4'b01_01) begin
      n_err++; $display("FAIL pair_enter_b: got %b want %b", {bus.entry_state, bus.display_select}, 4'b01_01);
    end
    press(4'd2); press(4'd12);
    n_cmp++;
    if (bus.operands_valid !== 1'b1) begin
      n_err++; $display("FAIL pair_valid_hi: got %b want %b", bus.operands_valid, 1'b1);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.operands_valid !== 1'b0) begin
      n_err++; $display("FAIL pair_valid_lo: got %b want %b", bus.operands_valid, 1'b0);
    end
    n_cmp++;
    if ({bus.bcdneg_A, a_val, bus.bcdneg_B, b_val} !== 32'hA009_F002) begin
      n_err++; $display("FAIL pair_operands: got %h want %h",
                        {bus.bcdneg_A, a_val, bus.bcdneg_B, b_val}, 32'hA009_F002);
    end
    n_cmp++;
    if ({bus.entry_state, bus.display_select} !== 4'b10_00) begin
      n_err++; $display("FAIL pair_ready: got %b want %b", {bus.entry_state, bus.display_select}, 4'b10_00);
    end
    press(4'd5); press(4'd10); press(4'd12);
    n_cmp++;
    if ({bus.operands_valid, bus.bcdneg_A, a_val, bus.bcdneg_B, b_val} !== 33'h0_A009_F002) begin
      n_err++; $display("FAIL ready_frozen: got %h want %h",
                        {bus.operands_valid, bus.bcdneg_A, a_val, bus.bcdneg_B, b_val}, 33'h0_A009_F002);
    end
    press(4'd11);
    n_cmp++;
    if ({bus.entry_state, a_val, b_val, bus.bcdneg_A} !== 30'h0_000000_F) begin
      n_err++; $display("FAIL ready_clear: got %h want %h", {bus.entry_state, a_val, b_val, bus.bcdneg_A}, 30'h0_000000_F);
    end
  endtask

  task automatic test_error();
    press(4'd11);
    press(4'd12); press(4'd3); press(4'd14);
    n_cmp++;
    if ({bus.entry_state, bus.display_select} !== 4'b11_10) begin
      n_err++; $display("FAIL error_enter: got %b want %b", {bus.entry_state, bus.display_select}, 4'b11_10);
    end
    press(4'd5); press(4'd12);
    n_cmp++;
    if ({bus.entry_state, bus.operands_valid, b_val} !== 15'b11_0_0000_0000_0011) begin
      n_err++; $display("FAIL error_hold: got %b want %b",
                        {bus.entry_state, bus.operands_valid, b_val}, 15'b11_0_0000_0000_0011);
    end
    press(4'd11);
    n_cmp++;
    if ({bus.entry_state, bus.display_select, a_val, b_val} !== 28'h0_000000) begin
      n_err++; $display("FAIL error_clear: got %h want %h",
                        {bus.entry_state, bus.display_select, a_val, b_val}, 28'h0_000000);
    end
  endtask

  task automatic test_sign_zero();
    press(4'd11);
    press(4'd12); press(4'd10);
    n_cmp++;
    if ({bus.bcdneg_A, bus.bcdneg_B, b_val} !== 20'hFA000) begin
      n_err++; $display("FAIL sign_zero_neg: got %h want %h", {bus.bcdneg_A, bus.bcdneg_B, b_val}, 20'hFA000);
    end
    press(4'd10);
    n_cmp++;
    if (bus.bcdneg_B !== 4'hF) begin
      n_err++; $display("FAIL sign_zero_pos: got %h want %h", bus.bcdneg_B, 4'hF);
    end
  endtask

  task automatic test_back_to_back();
    press(4'd11);
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_code = 4'd7;
    @(negedge clk); bus.key_code = 4'd8;
    @(negedge clk); bus.key_code = 4'd10;
    @(negedge clk); bus.key_valid = 1'b0; bus.key_code = 4'd3;
    repeat (3) @(negedge clk);
    bus.key_code = 4'd0;
    n_cmp++;
    if ({bus.bcdneg_A, a_val} !== 16'hA078) begin
      n_err++; $display("FAIL back_to_back: got %h want %h", {bus.bcdneg_A, a_val}, 16'hA078);
    end
  endtask

  task automatic test_async_reset();
    press(4'd11);
    press(4'd1); press(4'd2); press(4'd12);
    n_cmp++;
    if ({bus.entry_state, a_val} !== 14'b01_0000_0001_0010) begin
      n_err++; $display("FAIL async_setup: got %b want %b", {bus.entry_state, a_val}, 14'b01_0000_0001_0010);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_val, b_val, bus.bcdneg_A, bus.bcdneg_B} !== 32'h000000FF) begin
      n_err++; $display("FAIL async_operands: got %h want %h",
                        {a_val, b_val, bus.bcdneg_A, bus.bcdneg_B}, 32'h000000FF);
    end
    n_cmp++;
    if ({bus.display_select, bus.operands_valid, bus.entry_state} !== 5'b00_0_00) begin
      n_err++; $display("FAIL async_ctrl: got %b want %b",
                        {bus.display_select, bus.operands_valid, bus.entry_state}, 5'b00_0_00);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    press(4'd11);
    press(4'd3);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (a_val !== 12'h003) begin n_err++; $display("FAIL timeout_early: got %h want %h", a_val, 12'h003); end
    @(negedge clk);
    n_cmp++;
    if ({bus.entry_state, a_val} !== 14'b00_0000_0000_0000) begin
      n_err++; $display("FAIL timeout_clear: got %b want %b", {bus.entry_state, a_val}, 14'b0);
    end
    press(4'd3);
    repeat (15) @(negedge clk);
    bus.key_valid = 1'b1; bus.key_code = 4'd4;
    @(negedge clk);
    bus.key_valid = 1'b0; bus.key_code = 4'd0;
    n_cmp++;
    if (a_val !== 12'h034) begin n_err++; $display("FAIL timeout_key_wins: got %h want %h", a_val, 12'h034); end
    repeat (15) @(negedge clk);
    n_cmp++;
    if (a_val !== 12'h034) begin n_err++; $display("FAIL timeout_restart: got %h want %h", a_val, 12'h034); end
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_overflow();
    test_pair();
    test_error();
    test_sign_zero();
    test_back_to_back();
    test_async_reset();
`ifdef ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Keypad-driven operand entry controller for the calculator front end. It sits between the key scanner and the display multiplexer. It accumulates two signed 3-digit BCD operands (A, then B) from a strobed key stream, holds them as per-digit character codes, drives `display_select`, and flags completed operand pairs to the arithmetic unit.

## Interface
Parameters:
- `NEG_CODE`, default 4'hA: sign-character code shown for a negative operand.
- `BLANK_CODE`, default 4'hF: sign-character code shown for a positive operand.
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity limit in clock cycles; used only with `ENTRY_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid while it is high.
- `key_code` in 4: 0–9 digit, 10 sign toggle, 11 clear, 12 enter, 13–15 invalid.
- `hex0char_A`, `hex1char_A`, `hex2char_A` out 4 each: operand A BCD digits, units/tens/hundreds.
- `bcdneg_A` out 4: operand A sign character.
- `hex0char_B`, `hex1char_B`, `hex2char_B`, `bcdneg_B` out 4 each: the same for operand B.
- `display_select` out 2: 00 show A, 01 show B, 10 error pattern.
- `operands_valid` out 1: one-cycle pulse when the A/B pair is complete.
- `entry_state` out 2: current FSM state code, for debug.

## Operation
- **FSM states** (codes in brackets):
  - ENTER_A (00), `display_select`=00
  - ENTER_B (01), `display_select`=01
  - READY (10), `display_select`=00
  - ERROR (11), `display_select`=10
- **Digit key (0–9)** in ENTER_A/ENTER_B acts on the active operand:
  - If hundreds = 0: shift left. Hundreds←tens, tens←units, units←key.
  - If hundreds ≠ 0: the key is ignored (3-digit overflow guard). Operand unchanged, no state change.
- **Sign (10)** in ENTER_A/ENTER_B: the active operand's sign toggles between `BLANK_CODE` and `NEG_CODE`. Allowed on value 000.
- **Enter (12):**
  - ENTER_A→ENTER_B.
  - ENTER_B→READY; `operands_valid` pulses in the cycle after the enter strobe is sampled.
- **Clear (11)** in any state:
  - All six digits→0, both signs→`BLANK_CODE`.
  - Next state ENTER_A.
- **Invalid code (13–15)** in ENTER_A/ENTER_B: →ERROR. Operand registers are unchanged.
- **READY:** operands frozen; every key except clear is ignored.
- **ERROR:** every key except clear is ignored; clear exits to ENTER_A.
- Only the active operand is ever modified. The inactive operand holds its value.

## Timing
- **Reset values:**
  - All digit outputs 0.
  - `bcdneg_A` = `bcdneg_B` = `BLANK_CODE`.
  - `display_select` 00, `operands_valid` 0, `entry_state` 00 (ENTER_A).
- Reset is asynchronous. Asserting it mid-entry immediately returns every output to the reset values; no partial key is retained.
- All outputs are registered. A key sampled with `key_valid`=1 on edge N is reflected on the outputs after edge N.
- `display_select` is decoded from the registered state. It changes in the same cycle as `entry_state`, with no extra cycle of latency.
- `operands_valid` is high for exactly one cycle per ENTER_B→READY transition. It never re-asserts while in READY.
- `key_valid` held high for consecutive cycles is treated as consecutive keys. The scanner guarantees one strobe per press.
- `key_code` is ignored when `key_valid`=0.

## Configuration
- **`ENTRY_TIMEOUT_EN` defined:**
  - A counter (width ≥ clog2(`TIMEOUT_CYCLES`)) runs in ENTER_A and ENTER_B.
  - It resets to 0 on any `key_valid` and on every state change.
  - When it reaches `TIMEOUT_CYCLES`−1 with no key, the block performs a clear: all operands zeroed, →ENTER_A.
  - The counter is held at 0 in READY and ERROR.
  - If a key and the timeout occur in the same cycle, the key wins and the counter restarts.
- **`ENTRY_TIMEOUT_EN` undefined:** no counter is built; entry waits indefinitely.

## Test plan
- Reset, then keys 1,2,3 → A digits hundreds/tens/units = 1/2/3, sign `BLANK_CODE`, `display_select`=00.
- Keys 4,5,6,7 in ENTER_A → A = 456; the 7 is ignored; state remains ENTER_A.
- Keys 9, sign, enter, 2, enter → A = 009 with sign `NEG_CODE`, B = 002; `operands_valid` pulses exactly one cycle; state READY; further digit keys leave A and B unchanged.
- Key 14 in ENTER_B → `display_select`=10 and state ERROR; digits 5 and enter are ignored; clear → all digits 0, state ENTER_A.
- Assert `rst_n`=0 mid-entry (A = 012, state ENTER_B) → all outputs at reset values asynchronously, before the next clock edge.
- With `ENTRY_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: enter digit 3, then idle 16 cycles → A cleared, state ENTER_A. A key on cycle 15 prevents the clear.
